// File: rtl/regfile_pkg.sv
// Shared defaults, clear-FSM state encoding and the write-bypass port selector
// for the multiport register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;
  localparam int MAX_WR     = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef struct packed {
    logic hit;
    logic idx;
  } byp_sel_t;

  // Highest-numbered matching write port wins, mirroring the array write priority.
  function automatic byp_sel_t bypass_sel(input logic [MAX_WR-1:0] match);
    byp_sel_t sel;
    sel = '{hit: 1'b0, idx: 1'b0};
    for (int j = 0; j < MAX_WR; j++) begin
      if (match[j]) begin
        sel.hit = 1'b1;
        sel.idx = j[0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set on issue,
// cleared on write or by the clear sequence, with one read mux per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_idx,
  input  logic [NUM_WR-1:0]        wr_act,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_act,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic [2**ADDR_W-1:0] busy;

  // NOTE: within one always_ff the last non-blocking assignment to a bit wins,
  // so placing the issue set after the write clears gives set priority.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      busy[clr_idx] <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_act[j]) busy[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (iss_act) busy[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with hardwired r0, busy scoreboard and a sequential
// clear after reset. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     init_busy
);

  localparam int DEPTH = 2**ADDR_W;

  state_t             state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic               blank;
  logic               clr_en;
  logic [NUM_WR-1:0]  wr_act;
  logic               iss_act;
  logic [NUM_RD-1:0]  busy_raw;
  logic [DATA_W-1:0]  mem [DEPTH];

  // Outputs are blanked whenever reset is held or the array is still being cleared.
  assign blank     = rst || (state == CLEAR);
  assign clr_en    = !rst && (state == CLEAR);
  assign init_busy = blank;
  assign iss_act   = !blank && iss_en && (iss_addr != '0);

  always_comb begin
    wr_act = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_act[j] = !blank && wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) state <= READY;
    end
  end

  // NOTE: the array has no reset branch; a parallel reset of every entry would
  // defeat RAM inference, so zeroing is left to the one-entry-per-cycle clear.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_act[j]) mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .clr_en   (clr_en),
    .clr_idx  (clr_cnt),
    .wr_act   (wr_act),
    .wr_addr  (wr_addr),
    .iss_act  (iss_act),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (busy_raw)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] dat;
    logic              bsy;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    logic [MAX_WR-1:0] match;
    byp_sel_t          sel;

    always_comb begin
      match = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        match[j] = wr_act[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra);
      end
    end

    assign sel = bypass_sel(match);
`endif

    always_comb begin
      dat = mem[ra];
      bsy = busy_raw[k];
`ifdef REGFILE_BYPASS_EN
      // A forwarded write also retires the pending flag unless re-issued this cycle.
      if (sel.hit) begin
        dat = wr_data[sel.idx*DATA_W +: DATA_W];
        bsy = iss_act && (iss_addr == ra);
      end
`endif
      if (blank || (ra == '0)) begin
        dat = '0;
        bsy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = dat;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: stimulus queues expected read values,
// a negedge monitor pops and compares them against the live outputs.
module tb_multiport_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              init_busy;

  multiport_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .NUM_WR (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DATA, K_BUSY, K_INIT} kind_t;
  typedef struct {
    string         name;
    kind_t         kind;
    int            port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Every expectation queued during a cycle refers to that cycle's outputs.
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [DW-1:0] act;
    while (q.size() != 0) begin
      e = q.pop_front();
      case (e.kind)
        K_DATA:  act = rd_data[e.port*DW +: DW];
        K_BUSY:  act = {{(DW-1){1'b0}}, rd_busy[e.port]};
        default: act = {{(DW-1){1'b0}}, init_busy};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_en  = 1'b0;
    iss_addr = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  task automatic exp_data(input string n, input int p, input logic [DW-1:0] v);
    q.push_back('{name: n, kind: K_DATA, port: p, exp: v});
  endtask

  task automatic exp_busy(input string n, input int p, input logic v);
    q.push_back('{name: n, kind: K_BUSY, port: p, exp: {{(DW-1){1'b0}}, v}});
  endtask

  task automatic exp_init(input string n, input logic v);
    q.push_back('{name: n, kind: K_INIT, port: 0, exp: {{(DW-1){1'b0}}, v}});
  endtask

  // 32 clear cycles with junk writes/issues that must be ignored.
  task automatic clear_phase(input string tag);
    for (int i = 0; i < 32; i++) begin
      idle();
      wr(0, 1, 32'hBAD1BAD1);
      wr(1, 31, 32'hBAD2BAD2);
      iss(2);
      rd(5, 31);
      exp_init({tag, "_init_hi"}, 1'b1);
      exp_data({tag, "_data_blank"}, 0, '0);
      exp_busy({tag, "_busy_blank"}, 1, 1'b0);
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd(0, 0);
    step();

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      rd(5, 7);
      exp_init("rst_init", 1'b1);
      exp_data("rst_data", 0, '0);
      exp_busy("rst_busy", 1, 1'b0);
      step();
    end
    rst = 1'b0;
    clear_phase("clr1");

    // Clear done: every address reads 0 and is not busy.
    for (int i = 0; i < 16; i++) begin
      rd(2*i, 2*i + 1);
      exp_init("ready_init_lo", 1'b0);
      exp_data("post_clear_p0", 0, '0);
      exp_data("post_clear_p1", 1, '0);
      exp_busy("post_clear_b0", 0, 1'b0);
      exp_busy("post_clear_b1", 1, 1'b0);
      step();
    end

    // Both ports write r5: port 1 wins.
    wr(0, 5, 32'hDEADBEEF);
    wr(1, 5, 32'h12345678);
    rd(5, 0);
    exp_data("r5_same_cycle", 0, BYP ? 32'h12345678 : 32'h0);
    exp_busy("r5_same_cycle_busy", 0, 1'b0);
    step();
    idle();
    rd(5, 5);
    exp_data("r5_port1_wins", 0, 32'h12345678);
    step();

    // r0 is hardwired.
    wr(0, 0, 32'hFFFFFFFF);
    iss(0);
    rd(0, 0);
    exp_data("r0_same_cycle", 0, '0);
    step();
    idle();
    rd(0, 0);
    exp_data("r0_read", 0, '0);
    exp_busy("r0_busy", 1, 1'b0);
    step();

    // Distinct-address writes on both ports.
    wr(0, 10, 32'hCAFE0001);
    wr(1, 20, 32'h0BADF00D);
    step();
    idle();
    rd(10, 20);
    exp_data("r10_p0", 0, 32'hCAFE0001);
    exp_data("r20_p1", 1, 32'h0BADF00D);
    step();

    // Issue r7, then write r7 with a same-cycle re-issue: busy stays set.
    iss(7);
    rd(0, 7);
    exp_busy("r7_issue_cycle", 1, 1'b0);
    step();
    idle();
    rd(0, 7);
    exp_busy("r7_after_issue", 1, 1'b1);
    step();
    wr(0, 7, 32'h00000077);
    iss(7);
    rd(0, 7);
    exp_data("r7_wr_iss_data", 1, BYP ? 32'h77 : 32'h0);
    exp_busy("r7_wr_iss_busy", 1, 1'b1);
    step();
    idle();
    rd(0, 7);
    exp_data("r7_after_wr", 1, 32'h77);
    exp_busy("r7_set_wins", 1, 1'b1);
    step();
    wr(1, 7, 32'h00000088);
    rd(7, 0);
    exp_data("r7_wr_data", 0, BYP ? 32'h88 : 32'h77);
    exp_busy("r7_wr_busy", 0, BYP ? 1'b0 : 1'b1);
    step();
    idle();
    rd(7, 0);
    exp_data("r7_final_data", 0, 32'h88);
    exp_busy("r7_cleared", 0, 1'b0);
    step();

    // Bypass of a write to r3 that was pending.
    wr(0, 3, 32'h11111111);
    iss(3);
    step();
    idle();
    wr(1, 3, 32'hA5A5A5A5);
    rd(3, 0);
    exp_data("r3_bypass_data", 0, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    exp_busy("r3_bypass_busy", 0, BYP ? 1'b0 : 1'b1);
    step();
    idle();
    rd(0, 3);
    exp_data("r3_stored", 1, 32'hA5A5A5A5);
    exp_busy("r3_not_busy", 1, 1'b0);
    step();

    // Leave r25 busy so the next clear has a set bit to remove.
    iss(25);
    step();
    idle();
    rd(0, 25);
    exp_busy("r25_busy", 1, 1'b1);
    step();

    // Reset, then re-assert reset at clr_cnt=10.
    rst = 1'b1;
    exp_init("rst2_init", 1'b1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_init("partial_init", 1'b1);
      step();
    end
    rst = 1'b1;
    exp_init("rst3_init", 1'b1);
    step();
    exp_init("rst3_init_hold", 1'b1);
    step();
    rst = 1'b0;
    clear_phase("clr2");

    rd(25, 20);
    exp_init("restart_init_lo", 1'b0);
    exp_busy("r25_cleared", 0, 1'b0);
    exp_data("r20_cleared", 1, '0);
    step();
    rd(1, 2);
    exp_data("r1_clear_write_ignored", 0, '0);
    exp_busy("r2_clear_issue_ignored", 1, 1'b0);
    step();
    rd(31, 5);
    exp_data("r31_clear_write_ignored", 0, '0);
    exp_data("r5_cleared", 1, '0);
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, legal 1..4: number of read ports.
REQ-004 Parameter NUM_WR, default 2, legal 1..2: number of write ports.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
REQ-009 rd_busy  out  NUM_RD  scoreboard busy bit of the register addressed by each read port.
REQ-010 wr_en  in  NUM_WR  per-port write enable.
REQ-011 wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
REQ-012 wr_data  in  NUM_WR*DATA_W  packed write data.
REQ-013 iss_en  in  1  marks iss_addr as having a pending write (instruction issued).
REQ-014 iss_addr  in  ADDR_W  destination register being issued.
REQ-015 init_busy  out  1  high while the clear sequence runs; array contents are not valid.

Function
REQ-016 Clear FSM states: CLEAR, READY; rst forces CLEAR with clr_cnt=0 on the next edge.
REQ-017 In CLEAR with rst low: one entry per cycle (entry clr_cnt) is written to 0 and its busy bit is cleared; clr_cnt increments by 1.
REQ-018 CLEAR -> READY on the edge that clears entry 2**ADDR_W-1; full clear takes 2**ADDR_W cycles after rst falls.
REQ-019 init_busy = 1 in CLEAR, 0 in READY.
REQ-020 In CLEAR: wr_en and iss_en are ignored, all rd_data read 0, and all rd_busy read 0.
REQ-021 rst asserted mid-clear restarts the sequence from clr_cnt=0.
REQ-022 Register 0 is hardwired: writes and issues to address 0 are discarded; reads return 0 and rd_busy returns 0.
REQ-023 In READY, wr_en[j] writes wr_data[j] to wr_addr[j] at the edge; the new value is visible on the following cycle.
REQ-024 When both write ports target the same nonzero address in the same cycle, port NUM_WR-1 wins.
REQ-025 Scoreboard: iss_en sets busy[iss_addr] at the edge; any wr_en to an address clears its busy bit at the edge.
REQ-026 When an issue and a write hit the same address in the same cycle, set wins and busy stays 1.
REQ-027 Reads are asynchronous: rd_data[k] = array[rd_addr[k]] (subject to REQ-030), and rd_busy[k] = busy[rd_addr[k]].

Reset
REQ-028 With rst high: init_busy=1, all rd_data=0, all rd_busy=0, clr_cnt=0, state=CLEAR.
REQ-029 No storage element is reset in parallel; the array and busy bits are zeroed only by the clear sequence.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined (READY only): a read port whose nonzero rd_addr matches a same-cycle write returns that wr_data (highest matching port wins), and its rd_busy reads 0 unless iss_en targets the same address in that cycle.
REQ-031 Without REGFILE_BYPASS_EN: reads return the stored value, and rd_busy reflects the stored busy bit only.

Structure
REQ-032 Package regfile_pkg holds the DATA_W, ADDR_W, NUM_RD and NUM_WR defaults, the CLEAR/READY state encoding, and a bypass-select helper function.
REQ-033 Sub-module regfile_scoreboard holds the busy-bit array, the set/clear priority logic and the busy read muxes; the top level holds the data array, the clear FSM and the bypass logic.

Verification
REQ-034 Drop rst after 3 cycles: init_busy is high for exactly 32 cycles, then low; a read of every address returns 0.
REQ-035 In READY, write 0xDEADBEEF to r5 via port 0 and 0x12345678 to r5 via port 1 in the same cycle: the next-cycle read of r5 returns 0x12345678.
REQ-036 Write 0xFFFFFFFF to r0: a read of r0 returns 0; issue to r0: rd_busy stays 0.
REQ-037 Issue r7, then in a later cycle write r7 together with iss_en=1 on r7: busy is 1 after the issue and remains 1 after the write.
REQ-038 With bypass on, write 0xA5A5A5A5 to r3 while reading r3 in the same cycle: rd_data=0xA5A5A5A5 and rd_busy=0; with bypass off, the old value is returned.
REQ-039 Assert rst at clr_cnt=10: the clear restarts and init_busy stays high 32 cycles after rst falls.
